multicycle_control: RTL and testbench

Multi-cycle main controller for the RISC-V datapath. It is the sequential successor of the single-cycle combinational decoder. It decodes opcode[6:0] of the latched instruction, steps a Moore FSM through FETCH/DECODE/EXEC/MEM/WB, and waits on a memory ready handshake with a bounded timeout. It also counts retired instructions and drives every datapath enable (PC, IR, register file, data memory, ALU muxes).

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 114 +++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath/memory bundle; master = controller, slave = datapath side
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [31:0]      instruction;
    logic             mem_ready;
    logic             zero;
    logic             pc_write;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic             busy;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] instret;

    modport master (
        input  run, instruction, mem_ready, zero,
        output pc_write, ir_write, mem_read, mem_write, mem_to_reg, reg_write, pc_src,
               alu_src_a, alu_src_b, alu_op, state, busy, fault, fault_code, instret
    );

    modport slave (
        output run, instruction, mem_ready, zero,
        input  pc_write, ir_write, mem_read, mem_write, mem_to_reg, reg_write, pc_src,
               alu_src_a, alu_src_b, alu_op, state, busy, fault, fault_code, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V main control FSM; define CTRL_ILLEGAL_TRAP_EN to fault on unsupported opcodes
module multicycle_control #(
    parameter int WAIT_MAX = 8,
    parameter int CNT_W    = 32
) (
    input logic clk,
    input logic rst_n,
    multicycle_control_if.master bus
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] W_LAST = WW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    state_t           st, nxt, done;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] instret;
    logic [1:0]       code, alu_src_b, alu_op;
    logic             mem_read, mem_write, reg_write, mem_to_reg, pc_src, alu_src_a;
    logic [6:0]       op;
    logic             is_r, is_i, is_ld, is_st, is_br, legal;
    logic             waiting, timeout, retire, trap, fetch_done, unused_bits;

    assign op          = bus.instruction[6:0];
    assign unused_bits = ^bus.instruction[31:7];
    assign is_r        = op == 7'b0110011;
    assign is_i        = op == 7'b0010011;
    assign is_ld       = op == 7'b0000011;
    assign is_st       = op == 7'b0100011;
    assign is_br       = op == 7'b1100011;
    assign legal       = is_r || is_i || is_ld || is_st || is_br;

    // timeout fires on the WAIT_MAX-th consecutive wait cycle; a ready on that cycle wins
    assign waiting = (st == FETCH || st == MEM) && !bus.mem_ready;
    assign timeout = waiting && wait_cnt == W_LAST;
    assign retire  = (st == EXEC && is_br) || (st == MEM && is_st && bus.mem_ready) || st == WB;
    assign done    = bus.run ? FETCH : IDLE;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = st == DECODE && !legal;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = done;
            FETCH:   nxt = timeout ? FAULT : bus.mem_ready ? DECODE : FETCH;
            DECODE:  nxt = legal ? EXEC : trap ? FAULT : done;
            EXEC:    nxt = is_br ? done : (is_ld || is_st) ? MEM : WB;
            MEM:     nxt = timeout ? FAULT : !bus.mem_ready ? MEM : is_st ? done : WB;
            WB:      nxt = done;
            default: nxt = FAULT;
        endcase
    end

    // enables are registered from the next state so they are valid on state entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            wait_cnt   <= '0;
            instret    <= '0;
            code       <= 2'b00;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            pc_src     <= 1'b0;
            alu_src_a  <= 1'b0;
            alu_src_b  <= 2'b00;
            alu_op     <= 2'b00;
        end else begin
            st         <= nxt;
            wait_cnt   <= (waiting && nxt == st) ? wait_cnt + WW'(1) : '0;
            instret    <= instret + CNT_W'(retire);
            code       <= timeout ? 2'b01 : trap ? 2'b10 : code;
            mem_read   <= nxt == FETCH || (nxt == MEM && is_ld);
            mem_write  <= nxt == MEM && is_st;
            reg_write  <= nxt == WB;
            mem_to_reg <= nxt == WB && is_ld;
            pc_src     <= nxt == EXEC && is_br;
            alu_src_a  <= nxt == EXEC;
            alu_src_b  <= nxt == FETCH ? 2'b01 : nxt == DECODE ? 2'b10 :
                          nxt == EXEC ? ((is_r || is_br) ? 2'b00 : 2'b10) : 2'b00;
            alu_op     <= nxt != EXEC ? 2'b00 : is_br ? 2'b01 : (is_r || is_i) ? 2'b10 : 2'b00;
        end
    end

    assign fetch_done     = st == FETCH && bus.mem_ready;
    assign bus.ir_write   = fetch_done;
    assign bus.pc_write   = fetch_done || (pc_src && bus.zero);
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.state      = st;
    assign bus.busy       = st != IDLE && st != FAULT;
    assign bus.fault      = st == FAULT;
    assign bus.fault_code = code;
    assign bus.instret    = instret;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized checks of the multi-cycle controller against a per-instruction state-path model
module tb_multicycle_control;
    localparam int WAIT_MAX = 8;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int exp_ret = 0;
    logic [11:0] outs;

    multicycle_control_if #(.CNT_W(32)) bus ();
    multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign outs = {bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.pc_write,
                   bus.ir_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {mem_read, mem_write, reg_write, mem_to_reg, pc_write, ir_write, pc_src, alu_src_a, alu_src_b, alu_op}
    function automatic logic [11:0] model_out(input logic [2:0] s, input logic [6:0] op,
                                              input logic rdy, input logic z);
        case (s)
            S_FETCH:  return {1'b1, 3'b000, rdy, rdy, 2'b00, 2'b01, 2'b00};
            S_DECODE: return {8'b0, 2'b10, 2'b00};
            S_EXEC: begin
                if (op == OP_BR) return {4'b0, z, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01};
                if (op == OP_R)  return {7'b0, 1'b1, 2'b00, 2'b10};
                if (op == OP_I)  return {7'b0, 1'b1, 2'b10, 2'b10};
                return {7'b0, 1'b1, 2'b10, 2'b00};
            end
            S_MEM:    return {op == OP_LD, op == OP_ST, 10'b0};
            S_WB:     return {2'b00, 1'b1, op == OP_LD, 8'b0};
            default:  return 12'b0;
        endcase
    endfunction

    // entered during the first FETCH cycle of an instruction; returns one edge after it ends
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic drop);
        logic [2:0] sq[$];
        logic       rq[$];
        logic [6:0] opc;
        logic       legal;
        logic [2:0] end_s;
        opc = ins[6:0];
        bus.instruction = ins;
        legal = opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR};
        repeat (fw) begin sq.push_back(S_FETCH); rq.push_back(1'b0); end
        sq.push_back(S_FETCH);  rq.push_back(1'b1);
        sq.push_back(S_DECODE); rq.push_back(1'($urandom()));
        if (legal) begin sq.push_back(S_EXEC); rq.push_back(1'($urandom())); end
        if (opc == OP_LD || opc == OP_ST) begin
            repeat (mw) begin sq.push_back(S_MEM); rq.push_back(1'b0); end
            sq.push_back(S_MEM); rq.push_back(1'b1);
        end
        if (opc inside {OP_R, OP_I, OP_LD}) begin sq.push_back(S_WB); rq.push_back(1'($urandom())); end
        end_s = drop ? S_IDLE : S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!legal) end_s = S_FAULT;
`endif
        foreach (sq[i]) begin
            @(negedge clk);
            bus.mem_ready = rq[i];
            bus.zero = z;
            if (drop && i > fw) bus.run = 1'b0;
            #1;
            chk($sformatf("state op=%0h cyc=%0d", opc, i), 32'(bus.state), 32'(sq[i]));
            chk($sformatf("outs op=%0h cyc=%0d", opc, i), 32'(outs), 32'(model_out(sq[i], opc, rq[i], z)));
            chk($sformatf("busy op=%0h cyc=%0d", opc, i), 32'(bus.busy), 32'd1);
        end
        if (legal) exp_ret++;
        @(posedge clk);
        #1;
        chk($sformatf("end_state op=%0h", opc), 32'(bus.state), 32'(end_s));
        chk($sformatf("fault_code op=%0h", opc), 32'(bus.fault_code), end_s == S_FAULT ? 32'd2 : 32'd0);
        chk($sformatf("instret op=%0h", opc), bus.instret, 32'(exp_ret));
    endtask

    initial begin
        logic [6:0]  ops[6];
        logic [31:0] r;
        int          k;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, 7'h7F};
        bus.run = 1'b0;
        bus.instruction = 32'h0;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(bus.state), 32'(S_IDLE));
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_fault", 32'(bus.fault), 32'd0);
        chk("reset_code", 32'(bus.fault_code), 32'd0);
        chk("reset_instret", bus.instret, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_hold", 32'(bus.state), 32'(S_IDLE));
        @(negedge clk);
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_to_fetch", 32'(bus.state), 32'(S_FETCH));

        run_instr(32'h007302B3, 0, 0, 1'b0, 1'b0);
        run_instr(32'h0002A303, 0, 0, 1'b0, 1'b0);
        run_instr(32'h0062A023, 0, 3, 1'b0, 1'b0);
        run_instr(32'h00628463, 0, 0, 1'b1, 1'b0);
        run_instr(32'h00628463, 0, 0, 1'b0, 1'b0);
        run_instr(32'h007302B3, WAIT_MAX - 1, 0, 1'b0, 1'b0);
        run_instr(32'h0002A303, 2, WAIT_MAX - 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            k = $urandom_range(0, 4);
`else
            k = $urandom_range(0, 5);
`endif
            r = $urandom();
            run_instr({r[31:7], ops[k]}, $urandom_range(0, WAIT_MAX - 1), $urandom_range(0, WAIT_MAX - 1),
                      1'($urandom()), 1'b0);
        end

        run_instr(32'h00A30293, 1, 0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("halted_state", 32'(bus.state), 32'(S_IDLE));
        chk("halted_outs", 32'(outs), 32'd0);
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_fetch", 32'(bus.state), 32'(S_FETCH));

        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_ret = 0;
        chk("trap_reset_state", 32'(bus.state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`endif

        run_instr(32'h007302B3, 0, 0, 1'b0, 1'b0);
        bus.instruction = 32'h0002A303;
        @(negedge clk); bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.mem_ready = 1'b0;
        #1;
        chk("mid_mem_state", 32'(bus.state), 32'(S_MEM));
        chk("mid_mem_read", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_ret = 0;
        chk("mid_mem_reset_state", 32'(bus.state), 32'(S_IDLE));
        chk("mid_mem_reset_instret", bus.instret, 32'd0);
        chk("mid_mem_reset_outs", 32'(outs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_fetch", 32'(bus.state), 32'(S_FETCH));

        run_instr(32'h007302B3, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            chk($sformatf("timeout_wait[%0d]", i), 32'(bus.state), 32'(S_FETCH));
        end
        @(posedge clk);
        #1;
        chk("timeout_state", 32'(bus.state), 32'(S_FAULT));
        chk("timeout_code", 32'(bus.fault_code), 32'd1);
        chk("timeout_fault", 32'(bus.fault), 32'd1);
        chk("timeout_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.run = ~bus.run;
            bus.mem_ready = 1'($urandom());
            bus.zero = 1'($urandom());
            #1;
            chk($sformatf("fault_sticky[%0d]", i), 32'(bus.state), 32'(S_FAULT));
            chk($sformatf("fault_outs[%0d]", i), 32'(outs), 32'd0);
            chk($sformatf("fault_code_hold[%0d]", i), 32'(bus.fault_code), 32'd1);
        end
        chk("fault_instret", bus.instret, 32'(exp_ret));
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("final_reset_state", 32'(bus.state), 32'(S_IDLE));
        chk("final_reset_instret", bus.instret, 32'd0);
        chk("final_reset_code", 32'(bus.fault_code), 32'd0);
        chk("final_reset_fault", 32'(bus.fault), 32'd0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
